accelbrot_com_deser: RTL

Word-serial to parallel collector placed directly downstream of the word-serial multi-word adder. It takes the LSW-first word stream, marked by start/valid flags, and assembles NUM_WORDS consecutive words into one full-width fixed-point value. It presents that value on a ready/valid output for the escape-check and compare logic. It also detects malformed frames and output overruns, since the upstream adder stream has no backpressure.

---
 rtl/accelbrot_com_pkg.sv | 21 ++
 rtl/accelbrot_com_deser.sv | 125 ++++++++++++
 2 files changed

// File: rtl/accelbrot_com_pkg.sv
// Items shared by the accelbrot datapath blocks: the default stream word
// width, the collector state encoding and the word-counter width helper.
package accelbrot_com_pkg;

  // The word-serial adder and the collector must agree on this width
  localparam int WWIDTH_DEFAULT = 34;

  // Collector states: waiting for a start word, or gathering a frame
  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  // Width of the word counter. The legal frame length is 2..16 words,
  // so $clog2 never returns 0 here. The guard keeps odd parameter values
  // from building a zero-width counter.
  function automatic int cntWidth(input int numWords);
    return (numWords < 2) ? 1 : $clog2(numWords);
  endfunction

endpackage

// File: rtl/accelbrot_com_deser.sv
// Word-serial to parallel collector. It assembles NUM_WORDS LSW-first
// stream words into one wide value and offers that value on a ready/valid
// output slot. The upstream stream cannot be stalled. Malformed framing
// therefore raises a one-cycle error pulse, and a frame that finds the slot
// still occupied is dropped and flagged with a sticky overflow bit.
module accelbrot_com_deser
  import accelbrot_com_pkg::*;
#(
  parameter int WWIDTH    = WWIDTH_DEFAULT,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WWIDTH-1:0]           d,
  input  logic                        d_start,
  input  logic                        d_valid,
  output logic [WWIDTH*NUM_WORDS-1:0] q,
  output logic                        q_valid,
  input  logic                        q_ready,
  output logic                        frm_err,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int CW = cntWidth(NUM_WORDS);
  localparam int QW = WWIDTH * NUM_WORDS;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [NUM_WORDS-1:0][WWIDTH-1:0]   asm_q, asm_d;
  logic [QW-1:0]                      oreg_q, oreg_d;
  logic                               qvalid_q, qvalid_d;
  logic                               frmerr_q, frmerr_d;
  logic                               ovf_q, ovf_d;
  logic                               complete;

  // Framing FSM, word capture and output-slot arbitration. The final word
  // goes straight from d into the output register, so the frame appears
  // one cycle after its last word. The word does not wait in the assembly
  // register first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    oreg_d   = oreg_q;
    qvalid_d = qvalid_q;
    frmerr_d = 1'b0;
    ovf_d    = ovf_q & ~ovf_clr;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_valid) begin
          if (d_start) begin
            asm_d[0] = d;
            cnt_d    = CW'(1);
            state_d  = COLLECT;
          end else begin
            frmerr_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (d_valid) begin
          if (d_start) begin
            frmerr_d = 1'b1;
            asm_d[0] = d;
            cnt_d    = CW'(1);
          end else begin
            asm_d[cnt_q] = d;
            if (cnt_q == LAST_IDX) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (qvalid_q && q_ready) begin
      qvalid_d = 1'b0;
    end

    if (complete) begin
      if (!qvalid_q || q_ready) begin
        oreg_d   = {d, asm_q[NUM_WORDS-2:0]};
        qvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers. Reset drops any partial frame and empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      asm_q    <= '0;
      oreg_q   <= '0;
      qvalid_q <= 1'b0;
      frmerr_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      oreg_q   <= oreg_d;
      qvalid_q <= qvalid_d;
      frmerr_q <= frmerr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign q       = oreg_q;
  assign q_valid = qvalid_q;
  assign frm_err = frmerr_q;
  assign ovf     = ovf_q;

endmodule
